// File: rtl/logic_fold_unit.sv
// Multi-operand bitwise fold (AND/OR/XOR/pass-last, optional inversion) over a
// valid/ready operand burst; one registered result per burst with beat count.
module logic_fold_unit #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             inv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    OUT  = 2'b10
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             inv_q, inv_d;
  logic             trunc_d;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    count_d;
  logic             err_d;
  logic             accept;

  // One bitwise combining step; anything other than AND/OR/XOR keeps the newest operand.
  function automatic logic [WIDTH-1:0] fold(input logic [1:0]       sel,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = b;
    endcase
    return r;
  endfunction

  // in_ready is registered and mirrors state_q != OUT, so it alone gates acceptance.
  assign accept = in_valid && in_ready;

  // Next-state, accumulator and result-capture logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    inv_d   = inv_q;
    trunc_d = 1'b0;
    data_d  = out_data;
    count_d = out_count;
    err_d   = out_err;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          inv_d   = inv;
          acc_d   = in_data;
          cnt_d   = CW'(1);
          state_d = in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = fold(op_q, acc_q, in_data);
          cnt_d = cnt_q + CW'(1);
          if (in_last) begin
            state_d = OUT;
          end else if (cnt_q == CW'(MAX_LEN - 1)) begin
            state_d = OUT;
            trunc_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result registers load only on entry to OUT and hold until the next burst ends.
    if ((state_q != OUT) && (state_d == OUT)) begin
      data_d  = inv_d ? ~acc_d : acc_d;
      count_d = cnt_d;
      err_d   = trunc_d;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      inv_q     <= inv_d;
      in_ready  <= (state_d != OUT);
      out_valid <= (state_d == OUT);
      out_data  <= data_d;
      out_count <= count_d;
      out_err   <= err_d;
    end
  end

endmodule
